// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like register bus and its arbiter.
package sram_like_pkg;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DATA_W   = 16;
    // Address MSB set marks a read access in the register map.
    localparam int unsigned READ_BIT = ADDR_W - 1;

    // Read data handed back when the slave never completes.
    localparam logic [DATA_W-1:0] ERR_DATA = 16'hDEAD;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/sram_like_arbiter_if.sv
// One sram-like bus link: request side driven by a master, handshake side by a slave.
interface sram_like_arbiter_if;
    import sram_like_pkg::*;

    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, wr, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_arbiter_watchdog.sv
// Saturating 8-bit transaction watchdog; expire fires in the cycle the count reaches TIMEOUT.
module sram_like_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] CNT_MAX   = 8'(TIMEOUT);
    localparam logic [7:0] EXPIRE_AT = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q;

    // Counter: clear wins over count; holds once TIMEOUT is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Expiry: this enabled cycle is the TIMEOUT-th one since the clear.
    always_comb begin
        expire = en && (cnt_q == EXPIRE_AT);
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-master round-robin arbiter for the sram-like register bus, one transaction in flight,
// with a watchdog that force-completes transactions the slave never finishes.
module sram_like_arbiter
    import sram_like_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_like_arbiter_if.slave  m0,
    sram_like_arbiter_if.slave  m1,
    sram_like_arbiter_if.master s,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              force_q, force_d;
    logic              terr_q;

    logic              wd_clr;
    logic              wd_en;
    logic              wd_expire;

    // Owner-side view before demultiplexing to m0/m1.
    logic              own_addr_ok;
    logic              own_data_ok;
    logic [DATA_W-1:0] own_rdata;

    sram_like_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // State, arbitration history and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            force_q <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            force_q <= force_d;
            terr_q  <= terr_q | force_d;
        end
    end

    // Next state, arbitration and owner-side completion.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        force_d     = 1'b0;
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
        own_addr_ok = 1'b0;
        own_data_ok = 1'b0;
        own_rdata   = '0;

        case (state_q)
            IDLE: begin
                // Cycle after a watchdog expiry: synthetic completion to the old owner.
                if (force_q) begin
                    own_data_ok = 1'b1;
                    own_rdata   = ERR_DATA;
                end
                if (m0.req || m1.req) begin
                    owner_d = (m0.req && m1.req) ? ~last_q : m1.req;
                    last_d  = owner_d;
                    state_d = GRANT;
                end
            end

            GRANT: begin
                own_addr_ok = s.addr_ok;
                own_rdata   = s.rdata;
                // A genuine completion here must coincide with addr_ok; a lone data_ok
                // is a stale answer to a timed-out transaction.
                own_data_ok = s.addr_ok & s.data_ok;
                if (s.addr_ok) begin
                    wd_clr  = 1'b1;
                    state_d = s.data_ok ? IDLE : WAIT;
                end
            end

            WAIT: begin
                wd_en       = 1'b1;
                own_rdata   = s.rdata;
                own_data_ok = s.data_ok;
                if (s.data_ok) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    state_d = IDLE;
                    force_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Slave-side request mux; only driven while in GRANT.
    always_comb begin
        s.req   = 1'b0;
        s.wr    = 1'b0;
        s.addr  = '0;
        s.wdata = '0;
        if (state_q == GRANT) begin
            s.req = 1'b1;
            if (owner_q) begin
                s.wr    = m1.wr;
                s.addr  = m1.addr;
                s.wdata = m1.wdata;
            end else begin
                s.wr    = m0.wr;
                s.addr  = m0.addr;
                s.wdata = m0.wdata;
            end
        end
    end

    // Master-side demux; the non-owner always sees zeros.
    always_comb begin
        m0.addr_ok = ~owner_q & own_addr_ok;
        m0.data_ok = ~owner_q & own_data_ok;
        m0.rdata   = owner_q ? '0 : own_rdata;
        m1.addr_ok = owner_q & own_addr_ok;
        m1.data_ok = owner_q & own_data_ok;
        m1.rdata   = owner_q ? own_rdata : '0;
    end

    // Status outputs.
    always_comb begin
        busy        = (state_q != IDLE);
        timeout_err = terr_q;
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter.
module tb_sram_like_arbiter;
    import sram_like_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic timeout_err;

    sram_like_arbiter_if m0_if ();
    sram_like_arbiter_if m1_if ();
    sram_like_arbiter_if s_if ();

    sram_like_arbiter #(
        .TIMEOUT (255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m0          (m0_if),
        .m1          (m1_if),
        .s           (s_if),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Event counters sampled on the inactive edge.
    int m0_dok_n = 0;
    int m1_dok_n = 0;
    int m0_aok_n = 0;
    int m1_nz_n  = 0;

    always @(negedge clk) begin
        if (m0_if.data_ok) m0_dok_n++;
        if (m1_if.data_ok) m1_dok_n++;
        if (m0_if.addr_ok) m0_aok_n++;
        if (m1_if.addr_ok || m1_if.data_ok || (m1_if.rdata != '0)) m1_nz_n++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_if.req = 1'b0; m0_if.wr = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.wr = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;
        s_if.addr_ok = 1'b0; s_if.data_ok = 1'b0; s_if.rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int d0, d1, n1, a0;

        // Reset state
        do_reset();
        sample();
        check("rst_busy", busy, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_s_req", s_if.req, 0);
        check("rst_s_addr", s_if.addr, 0);
        check("rst_m0_rdata", m0_if.rdata, 0);
        check("rst_m1_rdata", m1_if.rdata, 0);

        // Single m0 write, data_ok three cycles after addr_ok
        step();
        m0_if.req = 1'b1; m0_if.wr = 1'b1; m0_if.addr = 8'd1; m0_if.wdata = 16'h1234;
        d0 = m0_dok_n; n1 = m1_nz_n;
        sample();
        check("wr_idle_sreq", s_if.req, 0);
        step();
        sample();
        check("wr_grant_sreq", s_if.req, 1);
        check("wr_grant_swr", s_if.wr, 1);
        check("wr_grant_saddr", s_if.addr, 8'd1);
        check("wr_grant_swdata", s_if.wdata, 16'h1234);
        check("wr_grant_aok_early", m0_if.addr_ok, 0);
        step();
        s_if.addr_ok = 1'b1;
        sample();
        check("wr_m0_aok", m0_if.addr_ok, 1);
        step();
        s_if.addr_ok = 1'b0; m0_if.req = 1'b0;
        sample();
        check("wr_wait_sreq", s_if.req, 0);
        check("wr_wait_busy", busy, 1);
        step();
        step();
        s_if.data_ok = 1'b1;
        sample();
        check("wr_m0_dok", m0_if.data_ok, 1);
        step();
        s_if.data_ok = 1'b0;
        sample();
        check("wr_idle_busy", busy, 0);
        step();
        check("wr_dok_pulses", m0_dok_n - d0, 1);
        check("wr_m1_quiet", m1_nz_n - n1, 0);

        // Both masters requesting continuously: strict alternation from m0
        do_reset();
        m0_if.req = 1'b1; m0_if.wr = 1'b0; m0_if.addr = 8'd128;
        m1_if.req = 1'b1; m1_if.wr = 1'b0; m1_if.addr = 8'd128;
        for (int t = 0; t < 6; t++) begin
            step();
            s_if.addr_ok = 1'b1;
            sample();
            check($sformatf("rr%0d_m0_aok", t), m0_if.addr_ok, (t % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_m1_aok", t), m1_if.addr_ok, (t % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d_saddr", t), s_if.addr, 8'd128);
            step();
            s_if.addr_ok = 1'b0; s_if.data_ok = 1'b1; s_if.rdata = 16'h00A0 + 16'(t);
            sample();
            if (t % 2 == 0) begin
                check($sformatf("rr%0d_m0_rdata", t), m0_if.rdata, 16'h00A0 + t);
                check($sformatf("rr%0d_m1_rdata", t), m1_if.rdata, 0);
                check($sformatf("rr%0d_m1_dok", t), m1_if.data_ok, 0);
            end else begin
                check($sformatf("rr%0d_m1_rdata", t), m1_if.rdata, 16'h00A0 + t);
                check($sformatf("rr%0d_m0_rdata", t), m0_if.rdata, 0);
                check($sformatf("rr%0d_m0_dok", t), m0_if.data_ok, 0);
            end
            step();
            s_if.data_ok = 1'b0; s_if.rdata = '0;
            if (t == 5) begin
                m0_if.req = 1'b0; m1_if.req = 1'b0;
            end
        end

        // Zero-latency slave, m1 read
        do_reset();
        m1_if.req = 1'b1; m1_if.wr = 1'b0; m1_if.addr = 8'd132;
        step();
        s_if.addr_ok = 1'b1; s_if.data_ok = 1'b1; s_if.rdata = 16'h0005;
        sample();
        check("zl_m1_rdata", m1_if.rdata, 16'h0005);
        check("zl_m1_dok", m1_if.data_ok, 1);
        check("zl_m1_aok", m1_if.addr_ok, 1);
        check("zl_m0_dok", m0_if.data_ok, 0);
        check("zl_busy_grant", busy, 1);
        step();
        clear_inputs();
        sample();
        check("zl_busy_after", busy, 0);

        // Watchdog expiry on an m0 read, then a stale data_ok
        do_reset();
        m0_if.req = 1'b1; m0_if.wr = 1'b0; m0_if.addr = 8'd135;
        step();
        s_if.addr_ok = 1'b1;
        sample();
        check("to_m0_aok", m0_if.addr_ok, 1);
        step();
        s_if.addr_ok = 1'b0; m0_if.req = 1'b0;
        repeat (254) step();
        sample();
        check("to_wait255_busy", busy, 1);
        check("to_wait255_dok", m0_if.data_ok, 0);
        check("to_wait255_terr", timeout_err, 0);
        step();
        sample();
        check("to_force_dok", m0_if.data_ok, 1);
        check("to_force_rdata", m0_if.rdata, 16'hDEAD);
        check("to_terr", timeout_err, 1);
        check("to_force_busy", busy, 0);
        step();
        s_if.data_ok = 1'b1; s_if.rdata = 16'h1234;
        m1_if.req = 1'b1; m1_if.wr = 1'b0; m1_if.addr = 8'd130;
        sample();
        check("to_late_idle_dok", m0_if.data_ok, 0);
        check("to_late_idle_rdata", m0_if.rdata, 0);
        step();
        sample();
        check("to_late_grant_sreq", s_if.req, 1);
        check("to_late_grant_dok", m1_if.data_ok, 0);
        step();
        s_if.addr_ok = 1'b1; s_if.rdata = 16'h0042;
        sample();
        check("to_next_m1_dok", m1_if.data_ok, 1);
        check("to_next_m1_rdata", m1_if.rdata, 16'h0042);
        step();
        clear_inputs();
        sample();
        check("to_terr_sticky", timeout_err, 1);

        // Reset during WAIT of an m1 write, then m0 wins the tie
        do_reset();
        m1_if.req = 1'b1; m1_if.wr = 1'b1; m1_if.addr = 8'd5; m1_if.wdata = 16'h55AA;
        step();
        s_if.addr_ok = 1'b1;
        step();
        s_if.addr_ok = 1'b0; m1_if.req = 1'b0;
        step();
        d1 = m1_dok_n;
        m0_if.req = 1'b1; m0_if.wr = 1'b0; m0_if.addr = 8'd3;
        m1_if.req = 1'b1; m1_if.wr = 1'b0; m1_if.addr = 8'd4;
        s_if.data_ok = 1'b1;
        rst_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_sreq", s_if.req, 0);
        check("ar_swr", s_if.wr, 0);
        check("ar_saddr", s_if.addr, 0);
        check("ar_swdata", s_if.wdata, 0);
        check("ar_m1_dok", m1_if.data_ok, 0);
        check("ar_m1_rdata", m1_if.rdata, 0);
        s_if.data_ok = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        s_if.addr_ok = 1'b1; s_if.data_ok = 1'b1;
        sample();
        check("ar_first_saddr", s_if.addr, 8'd3);
        check("ar_first_m0_aok", m0_if.addr_ok, 1);
        check("ar_first_m1_aok", m1_if.addr_ok, 0);
        step();
        m0_if.req = 1'b0; s_if.addr_ok = 1'b0; s_if.data_ok = 1'b0;
        step();
        s_if.addr_ok = 1'b1; s_if.data_ok = 1'b1;
        sample();
        check("ar_second_saddr", s_if.addr, 8'd4);
        check("ar_second_m1_aok", m1_if.addr_ok, 1);
        step();
        clear_inputs();
        check("ar_m1_dok_count", m1_dok_n - d1, 1);

        // Slow addr_ok: s_req held for 10 cycles, no timeout
        do_reset();
        m0_if.req = 1'b1; m0_if.wr = 1'b1; m0_if.addr = 8'd9; m0_if.wdata = 16'h0909;
        a0 = m0_aok_n;
        step();
        for (int i = 0; i < 10; i++) begin
            sample();
            check($sformatf("slow_sreq%0d", i), s_if.req, 1);
            step();
        end
        s_if.addr_ok = 1'b1;
        sample();
        check("slow_m0_aok", m0_if.addr_ok, 1);
        step();
        s_if.addr_ok = 1'b0; m0_if.req = 1'b0;
        step();
        s_if.data_ok = 1'b1;
        step();
        s_if.data_ok = 1'b0;
        step();
        check("slow_aok_count", m0_aok_n - a0, 1);
        check("slow_terr", timeout_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
